// File: rtl/fnd_scan_driver.sv
// Binary-to-BCD (sequential double-dabble) conversion plus a 4-digit
// common-anode scanner that feeds the FND font decoder.
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_blank_all,
    output logic        o_busy,
    output logic [3:0]  o_fnd_com,
    output logic [3:0]  o_bcd,
    output logic        o_En
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [13:0]   bin_q, bin_nxt;
    logic [15:0]   acc_q, acc_nxt;
    logic [15:0]   acc_adj;
    logic [3:0]    cnt_q, cnt_nxt;
    logic          busy_nxt;
    logic [15:0]   disp_q, disp_nxt;

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q, idx_nxt;
    logic [3:0]    zero_from;
    logic          lz_blank;

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int n = 0; n < 4; n++) begin
            if (acc_q[4*n +: 4] >= 4'd5)
                acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_q;
        acc_nxt   = acc_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = o_busy;
        disp_nxt  = disp_q;
        case (state)
            ST_IDLE: begin
                if (i_load) begin
                    bin_nxt   = (i_value > 14'd9999) ? 14'd9999 : i_value;
                    acc_nxt   = 16'd0;
                    cnt_nxt   = 4'd0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_nxt = {acc_adj[14:0], bin_q[13]};
                bin_nxt = {bin_q[12:0], 1'b0};
                cnt_nxt = cnt_q + 4'd1;
                if (cnt_q == 4'd13)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Only a finished conversion ever reaches the display register.
                disp_nxt  = acc_q;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            bin_q  <= 14'd0;
            acc_q  <= 16'd0;
            cnt_q  <= 4'd0;
            o_busy <= 1'b0;
            disp_q <= 16'd0;
        end else begin
            state  <= state_nxt;
            bin_q  <= bin_nxt;
            acc_q  <= acc_nxt;
            cnt_q  <= cnt_nxt;
            o_busy <= busy_nxt;
            disp_q <= disp_nxt;
        end
    end

    // zero_from[k]: digit k and every higher digit are zero.
    always_comb begin
        zero_from[3] = (disp_q[15:12] == 4'd0);
        zero_from[2] = zero_from[3] && (disp_q[11:8] == 4'd0);
        zero_from[1] = zero_from[2] && (disp_q[7:4] == 4'd0);
        zero_from[0] = zero_from[1] && (disp_q[3:0] == 4'd0);
        idx_nxt      = idx_q + 2'd1;
        lz_blank     = LZ_BLANK && (idx_nxt != 2'd0) && zero_from[idx_nxt];
    end

    // Commons, digit and blank all move on the slot edge together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_q   <= '0;
            idx_q     <= 2'd0;
            o_fnd_com <= 4'b1110;
            o_bcd     <= 4'd0;
            o_En      <= 1'b0;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q   <= '0;
            idx_q     <= idx_nxt;
            o_fnd_com <= ~(4'b0001 << idx_nxt);
            o_bcd     <= disp_q[4*idx_nxt +: 4];
            o_En      <= i_blank_all || lz_blank;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver: two instances (leading-zero
// blanking on and off) share stimulus; each slot is compared against a model.
module tb_fnd_scan_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        blank_all;
  logic        busy, busy_n;
  logic [3:0]  com, com_n, bcd, bcd_n;
  logic        en, en_n;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_nq[$];

  always #5 clk = ~clk;

  fnd_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load),
    .i_blank_all(blank_all), .o_busy(busy), .o_fnd_com(com),
    .o_bcd(bcd), .o_En(en)
  );

  fnd_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut_nlz (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load),
    .i_blank_all(blank_all), .o_busy(busy_n), .o_fnd_com(com_n),
    .o_bcd(bcd_n), .o_En(en_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {com, En, bcd} for one slot.
  function automatic logic [8:0] exp_slot(input int v, input int idx, input bit lz, input bit ba);
    int vc, p;
    logic [3:0] c, d;
    logic e;
    vc = (v > 9999) ? 9999 : v;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    d = 4'((vc / p) % 10);
    e = ba || (lz && idx >= 1 && vc < p);
    c = 4'b1111;
    c[idx] = 1'b0;
    return {c, e, d};
  endfunction

  task automatic push_expect(input int v, input bit ba);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(exp_slot(v, k, 1'b1, ba));
      exp_nq.push_back(exp_slot(v, k, 1'b0, ba));
    end
  endtask

  task automatic pulse_load(input int v);
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Counts negedges with busy high after the load edge; bounded.
  task automatic measure_busy(input string tag, input bit do_check);
    int n;
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (do_check) check(tag, n, 15);
    else if (busy) check({tag, "_timeout"}, 1, 0);
  endtask

  // Align to the slot edge entering idx 0, then compare one full frame.
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    int guard;
    logic [8:0] e1, e2;
    guard = 0;
    prev = com;
    @(negedge clk);
    while (!(com == 4'b1110 && prev != 4'b1110) && guard < 64) begin
      prev = com;
      guard++;
      @(negedge clk);
    end
    if (guard >= 64) check({tag, "_align_timeout"}, 1, 0);
    for (int k = 0; k < 4; k++) begin
      e1 = exp_q.pop_front();
      e2 = exp_nq.pop_front();
      check($sformatf("%s_lz_idx%0d", tag, k), {com, en, bcd}, e1);
      check($sformatf("%s_nlz_idx%0d", tag, k), {com_n, en_n, bcd_n}, e2);
      repeat (SD) @(negedge clk);
    end
  endtask

  task automatic convert_and_check(input string tag, input int v);
    push_expect(v, 1'b0);
    pulse_load(v);
    measure_busy({tag, "_busy_len"}, 1'b1);
    check_frame(tag);
  endtask

  initial begin
    rst = 1'b1; value = '0; load = 1'b0; blank_all = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_com", com, 4'b1110);
    check("rst_bcd", bcd, 4'd0);
    check("rst_en", en, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] ec;
      @(negedge clk);
      ec = 4'b1111;
      ec[(n / SD) % 4] = 1'b0;
      check($sformatf("scan_com_c%0d", n), com, ec);
    end

    convert_and_check("v1234", 1234);
    convert_and_check("v16383", 16383);
    convert_and_check("v0", 0);
    convert_and_check("v7", 7);
    convert_and_check("v1005", 1005);
    convert_and_check("v9999", 9999);

    // Second load while busy must be dropped.
    push_expect(42, 1'b0);
    pulse_load(42);
    repeat (2) @(negedge clk);
    value = 14'd9000;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    measure_busy("busy_drop", 1'b0);
    check_frame("v42");
    convert_and_check("v9000", 9000);

    // Back-to-back: reload on the cycle busy falls.
    push_expect(321, 1'b0);
    pulse_load(123);
    while (busy) @(negedge clk);
    value = 14'd321;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("b2b_busy", busy, 1'b1);
    measure_busy("b2b_wait", 1'b0);
    check_frame("v321");

    // Reset on cycle 7 of busy.
    push_expect(0, 1'b0);
    pulse_load(5678);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_com", com, 4'b1110);
    repeat (20) @(negedge clk);
    check("midrst_busy_stays", busy, 1'b0);
    check_frame("midrst");

    blank_all = 1'b1;
    push_expect(0, 1'b1);
    check_frame("blank_all");
    blank_all = 1'b0;
    convert_and_check("v50", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
